// File: rtl/exp_sched.sv
// Round-robin arbiter that shares one exponential engine among N_REQ requesters.
// Each accepted operand is issued, waited on (with a hang timeout) and returned tagged with its requester id.
module exp_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_x,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [1:0]            resp_int,
  output logic [15:0]           resp_frac,
  output logic                  resp_timeout,
  output logic                  busy,
  output logic                  exp_start,
  output logic [15:0]           exp_x,
  input  logic                  exp_done,
  input  logic [1:0]            exp_int,
  input  logic [15:0]           exp_frac
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       exp_x_q, exp_x_d;
  logic              exp_start_q, exp_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [1:0]        resp_int_q, resp_int_d;
  logic [15:0]       resp_frac_q, resp_frac_d;
  logic              resp_timeout_q, resp_timeout_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   cand;
  logic [15:0]       sel_x;
  logic              done_edge;

  // Search starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
    sel_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) sel_x = req_x[16*i +: 16];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    id_d           = id_q;
    cnt_d          = cnt_q;
    exp_x_d        = exp_x_q;
    resp_id_d      = resp_id_q;
    resp_int_d     = resp_int_q;
    resp_frac_d    = resp_frac_q;
    resp_timeout_d = resp_timeout_q;
    done_d         = exp_done;
    done_edge      = exp_done & ~done_q;
    req_ready      = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_ISSUE;
          ptr_d   = grant_id;
          id_d    = grant_id;
          exp_x_d = sel_x;
          // Accept strobe is combinational, so it is forced low while reset is held.
          if (rst) req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_edge) begin
          resp_int_d     = exp_int;
          resp_frac_d    = exp_frac;
          resp_timeout_d = 1'b0;
          resp_id_d      = id_q;
          exp_x_d        = '0;
          state_d        = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          resp_int_d     = '0;
          resp_frac_d    = '0;
          resp_timeout_d = 1'b1;
          resp_id_d      = id_q;
          exp_x_d        = '0;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes and busy are registered copies of the next state.
    exp_start_d  = (state_d == S_ISSUE);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      ptr_q          <= ID_W'(N_REQ - 1);
      id_q           <= '0;
      cnt_q          <= '0;
      exp_x_q        <= '0;
      exp_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_int_q     <= '0;
      resp_frac_q    <= '0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      id_q           <= id_d;
      cnt_q          <= cnt_d;
      exp_x_q        <= exp_x_d;
      exp_start_q    <= exp_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_int_q     <= resp_int_d;
      resp_frac_q    <= resp_frac_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign exp_start    = exp_start_q;
  assign exp_x        = exp_x_q;
  assign busy         = busy_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_int     = resp_int_q;
  assign resp_frac    = resp_frac_q;
  assign resp_timeout = resp_timeout_q;

endmodule
